// File: rtl/param_elastic_pipeline.sv
// param_elastic_pipeline: DEPTH-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush, per-stage taps and occupancy count.
module param_elastic_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v, adv, vin;
  logic [DEPTH*WIDTH-1:0] sd, din;
  // a stage may load when it is empty or its contents move on; ready ripples back from the output
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~v[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) adv[i] = ~v[i] | adv[i+1];
  end
  assign in_ready = adv[0] & ~flush;
  assign vin = DEPTH'({v, in_valid & in_ready});
  assign din = (DEPTH*WIDTH)'({sd, in_data});
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(v[i]);
  end
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data = sd[(DEPTH-1)*WIDTH +: WIDTH];
  assign stage_valid = v;
  assign stage_data = sd;
  // data registers only load real beats so bubbles leave them untouched
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v <= '0;
      sd <= '0;
    end else if (flush) v <= '0;
    else
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) v[i] <= vin[i];
        if (adv[i] && vin[i]) sd[i*WIDTH +: WIDTH] <= din[i*WIDTH +: WIDTH];
      end
endmodule

// File: tb/tb_param_elastic_pipeline.sv
// tb_param_elastic_pipeline: vector table and corner sequences on a 3x8 instance, random
// scoreboard sweep on 1x16 and 5x16 instances.
module tb_param_elastic_pipeline;
  logic clk, rst;
  logic a_iv, a_ir, a_fl, a_ov, a_or;
  logic [7:0] a_d, a_od;
  logic [2:0] a_sv;
  logic [23:0] a_sd;
  logic [1:0] a_occ;
  logic b_iv, b_ir, b_ov, b_or;
  logic [15:0] b_d, b_od;
  logic [0:0] b_sv, b_occ;
  logic [15:0] b_sd;
  logic c_iv, c_ir, c_ov, c_or;
  logic [15:0] c_d, c_od;
  logic [4:0] c_sv;
  logic [79:0] c_sd;
  logic [2:0] c_occ;
  int errors = 0, checks = 0;

  param_elastic_pipeline #(.WIDTH(8), .DEPTH(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d), .flush(a_fl),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .stage_valid(a_sv),
    .stage_data(a_sd), .occupancy(a_occ));
  param_elastic_pipeline #(.WIDTH(16), .DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d), .flush(1'b0),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .stage_valid(b_sv),
    .stage_data(b_sd), .occupancy(b_occ));
  param_elastic_pipeline #(.WIDTH(16), .DEPTH(5)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_d), .flush(1'b0),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .stage_valid(c_sv),
    .stage_data(c_sd), .occupancy(c_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [7:0] d; logic ordy; logic fl;
    logic ir; logic ov; logic [7:0] od; logic [1:0] occ; logic [2:0] sv;
  } vec_t;
  typedef struct { logic [15:0] d; int t; } beat_t;
  vec_t tv[27];
  beat_t qb[$], qc[$];

  task automatic chk(input string n, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  initial begin
    tv[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 3'b000};
    tv[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1, 3'b001};
    tv[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2, 3'b011};
    tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 2'd3, 3'b111};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 2'd2, 3'b110};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 2'd1, 3'b100};
    tv[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'd0, 3'b000};
    tv[7]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'd0, 3'b000};
    tv[8]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'd1, 3'b001};
    tv[9]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'd2, 3'b011};
    tv[10] = '{1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 2'd3, 3'b111};
    tv[11] = '{1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 2'd3, 3'b111};
    tv[12] = '{1'b1, 8'hDD, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 2'd3, 3'b111};
    tv[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 2'd3, 3'b111};
    tv[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hCC, 2'd2, 3'b110};
    tv[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hDD, 2'd1, 3'b100};
    tv[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hDD, 2'd0, 3'b000};
    tv[17] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'hDD, 2'd0, 3'b000};
    tv[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hDD, 2'd1, 3'b001};
    tv[19] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'hDD, 2'd1, 3'b010};
    tv[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 3'b101};
    tv[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 3'b110};
    tv[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 3'b110};
    tv[23] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 3'b110};
    tv[24] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 2'd3, 3'b111};
    tv[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 2'd0, 3'b000};
    tv[26] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 2'd0, 3'b000};
    rst = 1'b0;
    {a_iv, a_d, a_fl, a_or} = '0;
    {b_iv, b_d, b_or, c_iv, c_d, c_or} = '0;
    @(negedge clk);
    #1;
    chk("reset_out_valid", a_ov, 1'b0);
    chk("reset_out_data", a_od, 8'h00);
    chk("reset_occupancy", a_occ, 2'd0);
    chk("reset_stage_data", a_sd, 24'h0);
    chk("reset_in_ready", a_ir, 1'b1);
    rst = 1'b1;
    foreach (tv[i]) begin
      @(negedge clk);
      a_iv = tv[i].iv; a_d = tv[i].d; a_or = tv[i].ordy; a_fl = tv[i].fl;
      #1;
      chk($sformatf("row%0d_in_ready", i), a_ir, tv[i].ir);
      chk($sformatf("row%0d_out_valid", i), a_ov, tv[i].ov);
      chk($sformatf("row%0d_out_data", i), a_od, tv[i].od);
      chk($sformatf("row%0d_occupancy", i), a_occ, tv[i].occ);
      chk($sformatf("row%0d_stage_valid", i), a_sv, tv[i].sv);
    end
    chk("flush_data_hold", a_sd, 24'h112233);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_iv = 1'b1; a_d = 8'hC3; a_or = 1'b0;
    end
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    chk("full_occupancy", a_occ, 2'd3);
    chk("full_out_data", a_od, 8'hC3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", a_ov, 1'b0);
    chk("async_out_data", a_od, 8'h00);
    chk("async_occupancy", a_occ, 2'd0);
    chk("async_stage_valid", a_sv, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    a_iv = 1'b1; a_d = 8'h5A; a_or = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("relaunch_valid_%0d", k), a_ov, k == 3);
      if (k == 3) chk("relaunch_data", a_od, 8'h5A);
      @(negedge clk);
      a_iv = 1'b0;
    end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      b_iv = $urandom_range(0, 3) != 0; b_d = 16'($urandom);
      b_or = cyc >= 600 ? 1'b1 : 1'($urandom_range(0, 1));
      c_iv = $urandom_range(0, 3) != 0; c_d = 16'($urandom);
      c_or = cyc >= 600 ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("d1_in_ready", b_ir, !(qb.size() == 1 && !b_or));
      chk("d1_occupancy", b_occ, qb.size());
      chk("d1_out_valid", b_ov, qb.size() > 0 && cyc - qb[0].t >= 1);
      if (b_ov && qb.size() > 0) chk("d1_out_data", b_od, qb[0].d);
      if (b_ov && b_or && qb.size() > 0) void'(qb.pop_front());
      if (b_iv && b_ir) qb.push_back('{b_d, cyc});
      chk("d5_in_ready", c_ir, !(qc.size() == 5 && !c_or));
      chk("d5_occupancy", c_occ, qc.size());
      chk("d5_out_valid", c_ov, qc.size() > 0 && cyc - qc[0].t >= 5);
      if (c_ov && qc.size() > 0) chk("d5_out_data", c_od, qc[0].d);
      if (c_ov && c_or && qc.size() > 0) void'(qc.pop_front());
      if (c_iv && c_ir) qc.push_back('{c_d, cyc});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
